conway_run_ctrl: RTL

- Sequencer that sits directly upstream of the 8x8 Conway core and drives its INITIAL_STATE, CLK_EN and LOAD_RUN inputs.
- Accepts a pattern as eight byte-wide rows over a valid/ready interface, commits it into core memory, then steps generations.
- Watches the core's CURRENT_STATE/NEXT_STATE and stops on extinction, still life or a generation limit.
- Reports the stop reason and the number of generations run.

---
 rtl/conway_run_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/conway_run_ctrl.sv
// Load/commit/run sequencer for the 8x8 Conway core; stops on extinction, still life or limit.
// Optional period-2 stop detection is built when CONWAY_PERIOD2_DETECT_EN is defined.
module conway_run_ctrl #(
    parameter int GEN_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [GEN_W-1:0] RUN_GENS,
    input  logic [7:0]       ROW_DATA,
    input  logic             ROW_VALID,
    output logic             ROW_READY,
    input  logic [63:0]      CURRENT_STATE,
    input  logic [63:0]      NEXT_STATE,
    output logic [63:0]      INITIAL_STATE,
    output logic             CLK_EN,
    output logic             LOAD_RUN,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       STOP_REASON,
    output logic [GEN_W-1:0] GEN_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [GEN_W-1:0] r_limit;
    logic [63:0]      r_init;
    logic [2:0]       r_idx;
    logic [GEN_W-1:0] r_gen;
    logic             r_done;
    logic [1:0]       r_reason;
    logic             r_load_run;
    logic             r_clk_en;
`ifdef CONWAY_PERIOD2_DETECT_EN
    logic [63:0]      r_prev;
`endif

    logic             w_en_req;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_stop;
    logic [1:0]       w_reason;

    always_comb begin
        w_next     = r_state;
        w_en_req   = 1'b0;
        w_start_ok = 1'b0;
        w_xfer     = 1'b0;
        w_stop     = 1'b0;
        w_reason   = 2'd0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_start_ok = 1'b1;
                    w_next     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ROW_VALID) begin
                    w_xfer = 1'b1;
                    if (r_idx == 3'd7)
                        w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_en_req = 1'b1;
                w_next   = S_RUN;
            end
            S_RUN: begin
                if (CURRENT_STATE == 64'd0) begin
                    w_stop   = 1'b1;
                    w_reason = 2'd1;
                end else if (NEXT_STATE == CURRENT_STATE) begin
                    w_stop   = 1'b1;
                    w_reason = 2'd2;
                end
`ifdef CONWAY_PERIOD2_DETECT_EN
                else if (r_gen != '0 && NEXT_STATE == r_prev) begin
                    w_stop   = 1'b1;
                    w_reason = 2'd3;
                end
`endif
                else if (r_gen == r_limit) begin
                    w_stop   = 1'b1;
                    w_reason = 2'd0;
                end
                if (w_stop)
                    w_next = S_DONE;
                else
                    w_en_req = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_limit    <= '0;
            r_init     <= '0;
            r_idx      <= '0;
            r_gen      <= '0;
            r_done     <= 1'b0;
            r_reason   <= 2'd0;
            r_load_run <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_limit    <= RUN_GENS;
                r_init     <= '0;
                r_idx      <= '0;
                r_gen      <= '0;
                r_done     <= 1'b0;
                r_load_run <= 1'b0;
            end
            if (w_xfer) begin
                r_init[8*r_idx +: 8] <= ROW_DATA;
                r_idx                <= r_idx + 3'd1;
            end
            if (r_state == S_COMMIT)
                r_load_run <= 1'b1;
            if (r_state == S_RUN) begin
                if (w_stop) begin
                    r_done   <= 1'b1;
                    r_reason <= w_reason;
                end else if (r_gen != '1) begin
                    r_gen <= r_gen + 1'b1;
                end
            end
        end
    end

`ifdef CONWAY_PERIOD2_DETECT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_prev <= '0;
        else if (r_state == S_COMMIT)
            r_prev <= '0;
        else if (r_state == S_RUN && !w_stop)
            r_prev <= CURRENT_STATE;
    end
`endif

    // Falling-edge retime keeps the gate stable while CLK is high.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_clk_en <= 1'b0;
        else
            r_clk_en <= w_en_req;
    end

    assign ROW_READY     = (r_state == S_LOAD);
    assign BUSY          = (r_state == S_LOAD) || (r_state == S_COMMIT)
                           || (r_state == S_RUN);
    assign INITIAL_STATE = r_init;
    assign CLK_EN        = r_clk_en;
    assign LOAD_RUN      = r_load_run;
    assign DONE          = r_done;
    assign STOP_REASON   = r_reason;
    assign GEN_COUNT     = r_gen;

endmodule
